mem_arbiter: RTL and testbench

Shared-memory arbiter between the per-core instruction and data caches and the single-ported RAM. It sits inside the memory control layer, behind the `cache_control_if` signals: each core's icache and dcache raise requests, one requester at a time owns the RAM, and every non-owner sees its wait asserted. Dcache requests take priority over icache requests. Cores are served round-robin. A grant is held across a multi-word cache block transaction up to a burst limit, so a dcache writeback-plus-fill is not interleaved with another requester.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: hands the single-ported RAM to one icache/dcache requester at a time.
// Dcache beats icache, cores rotate round-robin, and a grant is held across a block burst.
module mem_arbiter #(
  parameter int CPUS      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic                  ram_err
);
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_INIT = CW'(CPUS - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [1:0]    RS_ACCESS = 2'd2;
  localparam logic [1:0]    RS_ERROR  = 2'd3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   owner_cpu;
  logic            owner_d;
  logic [CW-1:0]   last_cpu;
  logic [BW-1:0]   burst_cnt;

  logic [CPUS-1:0] d_pend;
  logic [CPUS-1:0] win_vec;
  logic            win_found;
  logic            win_d;
  logic [CW-1:0]   win_cpu;
  logic            owner_pend;
  logic            is_access;
  logic            is_error;
  logic            release_grant;
  logic [BW-1:0]   burst_next;

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  // Winner search: dcache class first, then rotate from the core after the last winner.
  always_comb begin
    int idx;
    idx       = 0;
    d_pend    = dREN | dWEN;
    win_d     = |d_pend;
    win_vec   = win_d ? d_pend : iREN;
    win_found = 1'b0;
    win_cpu   = '0;
    for (int k = 1; k <= CPUS; k++) begin
      idx = int'(last_cpu) + k;
      if (idx >= CPUS) idx = idx - CPUS;
      if (!win_found && win_vec[CW'(idx)]) begin
        win_found = 1'b1;
        win_cpu   = CW'(idx);
      end
    end
  end

  // Owner routing; a dropped request leaves every RAM pin idle for this cycle.
  always_comb begin
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;
    iwait         = '1;
    dwait         = '1;
    is_access     = (ramstate == RS_ACCESS);
    is_error      = (ramstate == RS_ERROR);
    owner_pend    = owner_d ? (dREN[owner_cpu] | dWEN[owner_cpu]) : iREN[owner_cpu];
    burst_next    = burst_cnt + BW'(is_access);
    release_grant = !owner_pend ||
                    (is_access && (!owner_d || (burst_next == BURST_MAX)));
    if (state == GRANT) begin
      if (owner_d) begin
        dwait[owner_cpu] = !is_access;
        if (owner_pend) begin
          ramWEN   = dWEN[owner_cpu];
          ramREN   = dREN[owner_cpu] & ~dWEN[owner_cpu];
          ramaddr  = daddr[owner_cpu];
          ramstore = dstore[owner_cpu];
        end
      end else begin
        iwait[owner_cpu] = !is_access;
        if (owner_pend) begin
          ramREN  = 1'b1;
          ramaddr = iaddr[owner_cpu];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      owner_cpu <= '0;
      owner_d   <= 1'b0;
      last_cpu  <= LAST_INIT;
      burst_cnt <= '0;
      ram_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= GRANT;
            owner_cpu <= win_cpu;
            owner_d   <= win_d;
            last_cpu  <= win_cpu;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          burst_cnt <= burst_next;
          if (is_error) ram_err <= 1'b1;
          if (release_grant) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed arbitration scenarios plus randomized traffic compared
// against a request-level model of the ownership rules.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int CPUS      = 2;
  localparam int MAX_BURST = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic                  CLK = 1'b0;
  logic                  nRST = 1'b0;
  logic [CPUS-1:0]       iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore, iload, dload;
  logic                  ramREN, ramWEN, ram_err;
  logic [31:0]           ramaddr, ramstore, ramload;
  logic [1:0]            ramstate;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.CPUS(CPUS), .MAX_BURST(MAX_BURST)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: owner is a requester id (cpu*2 + is_d), -1 while the RAM is unowned.
  int m_owner = -1;
  int m_last  = CPUS - 1;
  int m_words = 0;
  bit m_err   = 1'b0;

  function automatic bit pending(int id);
    int c;
    c = id / 2;
    if ((id % 2) != 0) return dREN[c] | dWEN[c];
    return iREN[c];
  endfunction

  function automatic int choose();
    int id;
    for (int cls = 1; cls >= 0; cls--) begin
      for (int k = 1; k <= CPUS; k++) begin
        id = ((m_last + k) % CPUS) * 2 + cls;
        if (pending(id)) return id;
      end
    end
    return -1;
  endfunction

  always @(posedge CLK or negedge nRST) begin : model_seq
    bit keep;
    if (!nRST) begin
      m_owner = -1;
      m_last  = CPUS - 1;
      m_words = 0;
      m_err   = 1'b0;
    end else if (m_owner < 0) begin
      m_owner = choose();
      if (m_owner >= 0) begin
        m_last  = m_owner / 2;
        m_words = 0;
      end
    end else begin
      keep = pending(m_owner);
      if (ramstate == ERROR) m_err = 1'b1;
      if (ramstate == ACCESS) begin
        m_words++;
        if ((m_owner % 2) == 0 || m_words == MAX_BURST) keep = 1'b0;
      end
      if (!keep) m_owner = -1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    clear_inputs();
    step();
    step();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    iREN = '1; dREN = '1; dWEN = '1;
    daddr[0] = 32'h1234; dstore[0] = 32'h5678; ramstate = ACCESS;
    step();
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ram_pins: ren=%b wen=%b addr=%h store=%h, want 0 0 0 0",
               ramREN, ramWEN, ramaddr, ramstore);
    end
    n_checks++;
    if (iwait !== 2'b11 || dwait !== 2'b11 || ram_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_waits: iwait=%b dwait=%b ram_err=%b, want 11 11 0", iwait, dwait, ram_err);
    end
    step();
  endtask

  task automatic test_single_icache();
    apply_reset();
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || iwait !== 2'b11) begin
      n_fail++;
      $display("FAIL icache_cycle0: ren=%b iwait=%b, want 0 11", ramREN, iwait);
    end
    step(); ramstate = BUSY;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || iwait !== 2'b11) begin
      n_fail++;
      $display("FAIL icache_busy: ren=%b wen=%b addr=%h iwait=%b, want 1 0 40 11",
               ramREN, ramWEN, ramaddr, iwait);
    end
    step(); ramstate = ACCESS;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 2'b10 || dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL icache_access: ren=%b addr=%h iwait=%b dwait=%b, want 1 40 10 11",
               ramREN, ramaddr, iwait, dwait);
    end
    // request still high: one word per icache grant forces an IDLE cycle
    step(); ramstate = FREE;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || iwait !== 2'b11) begin
      n_fail++;
      $display("FAIL icache_release: ren=%b iwait=%b, want 0 11", ramREN, iwait);
    end
    step(); iREN[0] = 1'b0;
    step();
    step();
  endtask

  task automatic test_priority_rr();
    int          ids[4];
    logic [31:0] adr[4];
    logic [CPUS-1:0] ew_i, ew_d;
    ids = '{1, 3, 0, 2};
    adr = '{32'h2000, 32'h2100, 32'h1000, 32'h1100};
    apply_reset();
    iREN = '1; dREN = '1;
    iaddr[0] = 32'h1000; iaddr[1] = 32'h1100;
    daddr[0] = 32'h2000; daddr[1] = 32'h2100;
    for (int g = 0; g < 4; g++) begin
      ramstate = FREE;
      @(negedge CLK);
      n_checks++;
      if (ramREN !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle_gap[%0d]: ren=%b, want 0", g, ramREN);
      end
      step(); ramstate = ACCESS;
      ew_i = '1; ew_d = '1;
      if ((ids[g] % 2) != 0) ew_d[ids[g] / 2] = 1'b0;
      else                   ew_i[ids[g] / 2] = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (ramREN !== 1'b1 || ramaddr !== adr[g] || iwait !== ew_i || dwait !== ew_d) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: ren=%b addr=%h iwait=%b dwait=%b, want 1 %h %b %b",
                 g, ramREN, ramaddr, iwait, dwait, adr[g], ew_i, ew_d);
      end
      if ((ids[g] % 2) != 0) dREN[ids[g] / 2] = 1'b0;
      else                   iREN[ids[g] / 2] = 1'b0;
      step();
    end
  endtask

  task automatic test_dcache_burst();
    logic [31:0] ea, es;
    apply_reset();
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    dWEN[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'hA5A5_0000;
    step(); ramstate = BUSY;
    @(negedge CLK);
    n_checks++;
    if (ramWEN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 2'b11 || iwait !== 2'b11) begin
      n_fail++;
      $display("FAIL burst_busy: wen=%b addr=%h dwait=%b iwait=%b, want 1 100 11 11",
               ramWEN, ramaddr, dwait, iwait);
    end
    step();
    for (int w = 0; w < 4; w++) begin
      ea = 32'h100 + 32'(4 * w);
      es = 32'hA5A5_0000 + 32'(w);
      ramstate = ACCESS; daddr[1] = ea; dstore[1] = es;
      dWEN[1] = (w < 2); dREN[1] = (w >= 2);
      @(negedge CLK);
      n_checks++;
      if (ramWEN !== (w < 2) || ramREN !== (w >= 2) || ramaddr !== ea ||
          (w < 2 && ramstore !== es) || dwait !== 2'b01 || iwait !== 2'b11) begin
        n_fail++;
        $display("FAIL burst_word[%0d]: wen=%b ren=%b addr=%h store=%h dwait=%b iwait=%b, want addr %h store %h dwait 01 iwait 11",
                 w, ramWEN, ramREN, ramaddr, ramstore, dwait, iwait, ea, es);
      end
      step();
    end
    dREN[1] = 1'b0; dWEN[1] = 1'b0; ramstate = FREE;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 2'b11) begin
      n_fail++;
      $display("FAIL burst_release: ren=%b wen=%b iwait=%b, want 0 0 11", ramREN, ramWEN, iwait);
    end
    step(); ramstate = ACCESS;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 2'b10) begin
      n_fail++;
      $display("FAIL burst_then_i0: ren=%b addr=%h iwait=%b, want 1 40 10", ramREN, ramaddr, iwait);
    end
    iREN[0] = 1'b0;
    step(); ramstate = FREE;
    step();
  endtask

  task automatic test_burst_cap();
    apply_reset();
    dREN = '1; daddr[0] = 32'h200; daddr[1] = 32'h300;
    step();
    for (int w = 0; w < MAX_BURST; w++) begin
      ramstate = ACCESS;
      @(negedge CLK);
      n_checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h200 || dwait !== 2'b10) begin
        n_fail++;
        $display("FAIL cap_d0_word[%0d]: ren=%b addr=%h dwait=%b, want 1 200 10", w, ramREN, ramaddr, dwait);
      end
      step();
    end
    ramstate = FREE;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL cap_forced_release: ren=%b dwait=%b, want 0 11", ramREN, dwait);
    end
    step(); ramstate = ACCESS;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dwait !== 2'b01) begin
      n_fail++;
      $display("FAIL cap_d1_grant: ren=%b addr=%h dwait=%b, want 1 300 01", ramREN, ramaddr, dwait);
    end
    dREN[1] = 1'b0;
    step(); ramstate = FREE;
    step(); ramstate = BUSY;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h200 || dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL cap_d0_regrant: ren=%b addr=%h dwait=%b, want 1 200 11", ramREN, ramaddr, dwait);
    end
    dREN[0] = 1'b0;
    #1;
    n_checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_drop_busy: ren=%b wen=%b, want 0 0", ramREN, ramWEN);
    end
    step(); ramstate = FREE;
    step();
  endtask

  task automatic test_conflict_error();
    apply_reset();
    dREN[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h500; dstore[0] = 32'hDEAD_BEEF;
    step(); ramstate = ERROR;
    @(negedge CLK);
    n_checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h500 ||
        ramstore !== 32'hDEAD_BEEF || dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL conflict_write_wins: wen=%b ren=%b addr=%h store=%h dwait=%b, want 1 0 500 deadbeef 11",
               ramWEN, ramREN, ramaddr, ramstore, dwait);
    end
    step();
    @(negedge CLK);
    n_checks++;
    if (ram_err !== 1'b1 || ramWEN !== 1'b1 || dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL error_held: ram_err=%b wen=%b dwait=%b, want 1 1 11", ram_err, ramWEN, dwait);
    end
    step(); ramstate = ACCESS;
    @(negedge CLK);
    n_checks++;
    if (dwait !== 2'b10 || ram_err !== 1'b1) begin
      n_fail++;
      $display("FAIL error_then_access: dwait=%b ram_err=%b, want 10 1", dwait, ram_err);
    end
    dREN[0] = 1'b0; dWEN[0] = 1'b0;
    step(); ramstate = FREE;
    repeat (3) step();
    @(negedge CLK);
    n_checks++;
    if (ram_err !== 1'b1) begin
      n_fail++;
      $display("FAIL error_sticky: ram_err=%b, want 1", ram_err);
    end
    nRST = 1'b0;
    #1;
    n_checks++;
    if (ram_err !== 1'b0) begin
      n_fail++;
      $display("FAIL error_cleared_by_reset: ram_err=%b, want 0", ram_err);
    end
    step();
    nRST = 1'b1;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h600; ramstate = BUSY;
    step();
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin
      n_fail++;
      $display("FAIL midreset_pre: ren=%b addr=%h, want 1 600", ramREN, ramaddr);
    end
    dREN[1] = 1'b1; daddr[1] = 32'h700;
    nRST = 1'b0;
    #1;
    n_checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0 ||
        iwait !== 2'b11 || dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL midreset_async: ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b, want 0 0 0 0 11 11",
               ramREN, ramWEN, ramaddr, ramstore, iwait, dwait);
    end
    step();
    nRST = 1'b1; ramstate = FREE;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: ren=%b, want 0", ramREN);
    end
    step();
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin
      n_fail++;
      $display("FAIL midreset_core0_first: ren=%b addr=%h, want 1 600", ramREN, ramaddr);
    end
    dREN = '0;
    step();
    step();
  endtask

  task automatic test_random();
    logic            e_ren, e_wen;
    logic [31:0]     e_addr, e_store;
    logic [CPUS-1:0] e_iwait, e_dwait;
    int              c, r;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < CPUS; k++) begin
        if ($urandom_range(0, 3) == 0) iREN[k] = ~iREN[k];
        if ($urandom_range(0, 3) == 0) dREN[k] = ~dREN[k];
        if ($urandom_range(0, 6) == 0) dWEN[k] = ~dWEN[k];
        iaddr[k]  = $urandom;
        daddr[k]  = $urandom;
        dstore[k] = $urandom;
      end
      ramload = $urandom;
      r = $urandom_range(0, 19);
      ramstate = (r == 0) ? FREE : (r < 6) ? BUSY : (r < 19) ? ACCESS : ERROR;
      @(negedge CLK);
      e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
      e_iwait = '1; e_dwait = '1;
      if (m_owner >= 0) begin
        c = m_owner / 2;
        if ((m_owner % 2) != 0) begin
          e_dwait[c] = (ramstate != ACCESS);
          e_wen   = dWEN[c];
          e_ren   = dREN[c] & ~dWEN[c];
          e_addr  = daddr[c];
          e_store = dstore[c];
        end else begin
          e_iwait[c] = (ramstate != ACCESS);
          e_ren  = iREN[c];
          e_addr = iaddr[c];
        end
      end
      n_checks++;
      if (ramREN !== e_ren || ramWEN !== e_wen) begin
        n_fail++;
        $display("FAIL rand_enables[%0d]: ren=%b wen=%b, want %b %b", cyc, ramREN, ramWEN, e_ren, e_wen);
      end
      if (m_owner >= 0 && pending(m_owner)) begin
        n_checks++;
        if (ramaddr !== e_addr || (e_wen && ramstore !== e_store)) begin
          n_fail++;
          $display("FAIL rand_addr[%0d]: addr=%h store=%h, want %h %h", cyc, ramaddr, ramstore, e_addr, e_store);
        end
      end
      n_checks++;
      if (iwait !== e_iwait || dwait !== e_dwait) begin
        n_fail++;
        $display("FAIL rand_waits[%0d]: iwait=%b dwait=%b, want %b %b", cyc, iwait, dwait, e_iwait, e_dwait);
      end
      n_checks++;
      if (ram_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_ram_err[%0d]: ram_err=%b, want %b", cyc, ram_err, m_err);
      end
      n_checks++;
      if (iload[cyc % CPUS] !== ramload || dload[cyc % CPUS] !== ramload) begin
        n_fail++;
        $display("FAIL rand_load[%0d]: iload=%h dload=%h, want %h", cyc, iload[cyc % CPUS], dload[cyc % CPUS], ramload);
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_icache();
    test_priority_rr();
    test_dcache_burst();
    test_burst_cap();
    test_conflict_error();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
